// File: rtl/lfsr_batch_collector_pkg.sv
// Shared types and constants for the LFSR batch collector.
package lfsr_batch_collector_pkg;

  localparam int unsigned SampleW = 8;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLaunch = 3'd1,
    StRun    = 3'd2,
    StStore  = 3'd3,
    StErr    = 3'd4
  } state_t;

endpackage

// File: rtl/lfsr_sample_fifo.sv
// Circular sample FIFO with a registered head output and occupancy count.
module lfsr_sample_fifo
  import lfsr_batch_collector_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [SampleW-1:0]       din,
  input  logic                     pop,
  output logic [SampleW-1:0]       dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned FillW = PtrW + 1;

  logic [SampleW-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
  logic [FillW-1:0]   fill_q, fill_d;
  logic [SampleW-1:0] dout_q, dout_d;
  logic               push_en, pop_en;

  assign empty   = (fill_q == '0);
  assign full    = (fill_q == FillW'(DEPTH));
  assign pop_en  = pop && !empty;
  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign push_en = push && (!full || pop_en);
  assign rd_next = rd_ptr_q + PtrW'(1);

  always_comb begin
    fill_d = fill_q;
    unique case ({push_en, pop_en})
      2'b10:   fill_d = fill_q + FillW'(1);
      2'b01:   fill_d = fill_q - FillW'(1);
      default: fill_d = fill_q;
    endcase
  end

  // Head register tracks whichever entry becomes the head after this cycle.
  always_comb begin
    dout_d = dout_q;
    if (push_en && (empty || (pop_en && fill_q == FillW'(1)))) begin
      dout_d = din;
    end else if (pop_en && fill_q > FillW'(1)) begin
      dout_d = mem_q[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      dout_q   <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_en)  rd_ptr_q <= rd_next;
      fill_q <= fill_d;
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;
  assign fill = fill_q;

endmodule

// File: rtl/lfsr_batch_collector.sv
// Drives the LFSR generator once per sample and buffers a batch of results.
module lfsr_batch_collector
  import lfsr_batch_collector_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req,
  input  logic [7:0]             count,
  input  logic [7:0]             seq_base,
  input  logic                   abort,
  output logic                   gen_start,
  output logic [7:0]             gen_seq_num,
  input  logic                   gen_busy,
  input  logic [7:0]             gen_num,
  output logic                   out_valid,
  output logic [7:0]             out_data,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   active,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimerLast = TW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [7:0]    seq_q, seq_d;
  logic [7:0]    rem_q, rem_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          done_q, done_d;
  logic          push;
  logic          fifo_empty, fifo_full;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    rem_d   = rem_q;
    timer_d = timer_q;
    err_d   = err_q;
    done_d  = 1'b0;
    push    = 1'b0;
    if (abort) begin
      state_d = StIdle;
      rem_d   = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StErr: begin
          if (req) begin
            if (count != '0) begin
              seq_d   = seq_base;
              rem_d   = count;
              err_d   = 1'b0;
              timer_d = '0;
              state_d = StLaunch;
            end else begin
              done_d  = 1'b1;
              state_d = StIdle;
            end
          end
        end
        StLaunch: begin
          timer_d = timer_q + TW'(1);
          if (gen_busy) begin
            state_d = StRun;
          end else if (timer_q == TimerLast) begin
            state_d = StErr;
            err_d   = 1'b1;
          end
        end
        StRun: begin
          if (!gen_busy) state_d = StStore;
        end
        StStore: begin
          // gen_num stays valid while we stall; the generator waits for the next start.
          if (!fifo_full || out_ready) begin
            push    = 1'b1;
            seq_d   = seq_q + 8'd1;
            rem_d   = rem_q - 8'd1;
            timer_d = '0;
            if (rem_q == 8'd1) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StLaunch;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      seq_q   <= '0;
      rem_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      rem_q   <= rem_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  lfsr_sample_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .din  (gen_num),
    .pop  (out_ready),
    .dout (out_data),
    .empty(fifo_empty),
    .full (fifo_full),
    .fill (fill)
  );

  assign out_valid   = !fifo_empty;
  assign gen_start   = (state_q == StLaunch);
  assign gen_seq_num = seq_q;
  assign active      = (state_q == StLaunch) || (state_q == StRun) || (state_q == StStore);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_lfsr_batch_collector.sv
// Scoreboard bench for lfsr_batch_collector with a stub generator model.
module tb_lfsr_batch_collector;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst, req, abort, out_ready, gen_busy;
  logic [7:0] count, seq_base, gen_num;
  logic       gen_start, out_valid, active, done, err;
  logic [7:0] gen_seq_num, out_data;
  logic [$clog2(DEPTH):0] fill;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  logic [7:0] sb[$];
  bit stub_dead = 0;
  bit rand_ready = 0;

  lfsr_batch_collector #(
    .DEPTH  (DEPTH),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .count      (count),
    .seq_base   (seq_base),
    .abort      (abort),
    .gen_start  (gen_start),
    .gen_seq_num(gen_seq_num),
    .gen_busy   (gen_busy),
    .gen_num    (gen_num),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .fill       (fill),
    .active     (active),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stub generator: busy rises 2 cycles after start, stays 3 cycles, num = 0x40 + seq.
  int         g_phase, g_cnt;
  logic [7:0] g_seq;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      g_phase  <= 0;
      g_cnt    <= 0;
      g_seq    <= '0;
      gen_busy <= 1'b0;
      gen_num  <= '0;
    end else begin
      case (g_phase)
        0: if (gen_start && !stub_dead) begin
             g_seq <= gen_seq_num; g_cnt <= 1; g_phase <= 1;
           end
        1: if (g_cnt == 0) begin
             gen_busy <= 1'b1; g_cnt <= 2; g_phase <= 2;
           end else g_cnt <= g_cnt - 1;
        default: if (g_cnt == 0) begin
             gen_busy <= 1'b0; gen_num <= 8'h40 + g_seq; g_phase <= 0;
           end else g_cnt <= g_cnt - 1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every accepted output beat.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no output", out_data);
        end else begin
          chk("out_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1 out_ready = 1'($urandom % 2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: a batch yields 0x40 + (base + i) mod 256 for each completed sample.
  task automatic issue(input int cnt, input logic [7:0] base, input int nexp);
    for (int i = 0; i < nexp; i++) sb.push_back(8'(8'h40 + base + 8'(i)));
    req = 1'b1; count = 8'(cnt); seq_base = base;
    tick();
    req = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (done) got = 1;
    end
    chk(name, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_run(input string name, input int budget);
    bit got = 0;
    for (int i = 0; i < budget && !got; i++) begin
      tick();
      if (gen_busy && !gen_start && active) got = 1;
    end
    chk(name, {31'd0, got}, 32'd1);
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    chk(name, sb.size(), 0);
  endtask

  initial begin
    int d0, n;
    bit got;
    rst = 1'b1; req = 1'b0; abort = 1'b0; out_ready = 1'b0;
    count = '0; seq_base = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_fill", {29'd0, fill}, 0);
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_data", {24'd0, out_data}, 0);
    chk("rst_start", {31'd0, gen_start}, 0);
    chk("rst_active", {31'd0, active}, 0);
    chk("rst_err", {31'd0, err}, 0);

    // Plain batch
    out_ready = 1'b1;
    d0 = done_cnt;
    issue(3, 8'h05, 3);
    chk("batch_start", {31'd0, gen_start}, 1);
    chk("batch_seq0", {24'd0, gen_seq_num}, 32'h05);
    chk("batch_active", {31'd0, active}, 1);
    wait_done("batch_done", 80);
    repeat (3) tick();
    chk("batch_active_low", {31'd0, active}, 0);
    chk("batch_done_once", done_cnt - d0, 1);
    chk("batch_sb_empty", sb.size(), 0);

    // Backpressure into a 4-deep FIFO
    out_ready = 1'b0;
    issue(6, 8'h10, 6);
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      tick();
      if (fill == 3'(DEPTH)) got = 1;
    end
    chk("bp_reach_full", {31'd0, got}, 1);
    repeat (20) tick();
    chk("bp_fill_full", {29'd0, fill}, DEPTH);
    chk("bp_stalled_active", {31'd0, active}, 1);
    chk("bp_stalled_no_start", {31'd0, gen_start}, 0);
    out_ready = 1'b1;
    wait_done("bp_done", 200);
    drain("bp_sb_empty");
    chk("bp_fill_zero", {29'd0, fill}, 0);

    // Sequence wrap
    issue(2, 8'hFF, 2);
    chk("wrap_seq_ff", {24'd0, gen_seq_num}, 32'hFF);
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin tick(); if (!gen_start) got = 1; end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin tick(); if (gen_start) got = 1; end
    chk("wrap_relaunch", {31'd0, got}, 1);
    chk("wrap_seq_00", {24'd0, gen_seq_num}, 32'h00);
    wait_done("wrap_done", 80);
    drain("wrap_sb_empty");

    // Timeout
    stub_dead = 1;
    issue(1, 8'h22, 0);
    n = 0;
    do begin tick(); n++; end while (!err && n < 40);
    chk("to_cycles", n, 16);
    chk("to_err", {31'd0, err}, 1);
    chk("to_start_low", {31'd0, gen_start}, 0);
    chk("to_active_low", {31'd0, active}, 0);
    stub_dead = 0;
    issue(1, 8'h30, 1);
    chk("to_err_cleared", {31'd0, err}, 0);
    wait_done("to_recover_done", 80);
    drain("to_sb_empty");

    // Zero-count request
    d0 = done_cnt;
    issue(0, 8'h99, 0);
    chk("zero_done", {31'd0, done}, 1);
    chk("zero_no_start", {31'd0, gen_start}, 0);
    tick();
    chk("zero_done_pulse", {31'd0, done}, 0);
    chk("zero_idle", {31'd0, active | gen_start}, 0);

    // Abort during RUN of the second sample
    out_ready = 1'b0;
    issue(3, 8'h60, 1);
    got = 0;
    for (int i = 0; i < 80 && !got; i++) begin
      tick();
      if (fill == 1 && gen_busy && !gen_start && active) got = 1;
    end
    chk("abort_reach_run", {31'd0, got}, 1);
    d0 = done_cnt;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_inactive", {31'd0, active}, 0);
    chk("abort_no_start", {31'd0, gen_start}, 0);
    repeat (10) tick();
    chk("abort_fill_kept", {29'd0, fill}, 1);
    chk("abort_head", {24'd0, out_data}, 32'hA0);
    chk("abort_no_done", done_cnt - d0, 0);
    drain("abort_sb_empty");

    // Randomised batches with random consumer backpressure
    rand_ready = 1;
    for (int b = 0; b < 6; b++) begin
      int cnt;
      logic [7:0] base;
      cnt  = int'($urandom_range(1, 7));
      base = 8'($urandom);
      issue(cnt, base, cnt);
      wait_done("rand_done", 400);
    end
    rand_ready = 0;
    @(posedge clk);
    #2;
    drain("rand_sb_empty");

    // Asynchronous reset mid-RUN
    issue(2, 8'h70, 0);
    wait_run("rst_reach_run", 40);
    #3 rst = 1'b1;
    #1;
    chk("arst_fill", {29'd0, fill}, 0);
    chk("arst_valid", {31'd0, out_valid}, 0);
    chk("arst_data", {24'd0, out_data}, 0);
    chk("arst_outs", {29'd0, gen_start, active, done}, 0);
    chk("arst_seq", {24'd0, gen_seq_num}, 0);
    chk("arst_err", {31'd0, err}, 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    chk("arst_idle", {31'd0, active}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
